// File: rtl/div_sequencer_if.sv
// -----------------------------------------------------------------------------
// div_sequencer_if
// Bundles the EX-stage divide request/response signals exchanged between the
// pipeline (decoder/hazard side) and the iterative divide controller.
//
//   div_startE   : div/divu instruction valid in EX          (master -> slave)
//   div_signedE  : 1 = div (signed), 0 = divu                 (master -> slave)
//   srcaE        : dividend (rs)                              (master -> slave)
//   srcbE        : divisor (rt)                               (master -> slave)
//   cancel       : exception/flush of EX, aborts the divide   (master -> slave)
//   stall_ext    : EX held by another stall source            (master -> slave)
//   div_stall    : stall request for F/D/E, combinational     (slave -> master)
//   div_valid    : hi_o/lo_o hold the result for EX           (slave -> master)
//   hi_o         : remainder                                  (slave -> master)
//   lo_o         : quotient                                   (slave -> master)
//
// Modports: master = pipeline side, slave = divide controller.
// -----------------------------------------------------------------------------
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             div_startE;
  logic             div_signedE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             cancel;
  logic             stall_ext;
  logic             div_stall;
  logic             div_valid;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output div_startE, div_signedE, srcaE, srcbE, cancel, stall_ext,
    input  div_stall, div_valid, hi_o, lo_o
  );

  modport slave (
    input  div_startE, div_signedE, srcaE, srcbE, cancel, stall_ext,
    output div_stall, div_valid, hi_o, lo_o
  );
endinterface

// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
// Iterative radix-2 restoring divide controller for the EX stage. Accepts
// div/divu, runs WIDTH iterations while stalling the pipeline, then presents
// remainder (hi_o) and quotient (lo_o) with div_valid for one EX residency
// (longer if stall_ext holds EX).
//
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset
//   divBus : div_sequencer_if.slave (start/operands/cancel/stall_ext in,
//            div_stall/div_valid/hi_o/lo_o out)
// -----------------------------------------------------------------------------
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  div_sequencer_if.slave  divBus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO  = CW'(0);
  localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES      = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           nextState_s;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             negQ_r;
  logic             negR_r;
  logic             valid_r;
  logic [CW-1:0]    iterCnt_r;

  logic             load_s;
  logic             lastIter_s;
  logic [WIDTH:0]   partial_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] remNext_s;
  logic [WIDTH-1:0] quoNext_s;
  logic             stall_s;

  // Two's-complement negate when doNeg is set.
  function automatic logic [WIDTH-1:0] negIf(input logic [WIDTH-1:0] v,
                                             input logic doNeg);
    logic [WIDTH-1:0] res;
    if (doNeg) begin
      res = ~v + ONE;
    end else begin
      res = v;
    end
    return res;
  endfunction

  // Magnitude of v when interpreted as signed; raw value for unsigned.
  // The most negative value maps onto itself, which is the correct
  // unsigned magnitude, so the overflow case needs no special handling.
  function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v,
                                              input logic isSigned);
    return negIf(v, isSigned & v[WIDTH-1]);
  endfunction

  assign load_s     = (state_r == IDLE) & divBus.div_startE & ~divBus.cancel;
  assign lastIter_s = (iterCnt_r == LAST_ITER);

  // One restoring-divide step: shift {rem,quo} left and trial-subtract.
  // The remainder is always below the divisor, so when the trial succeeds
  // the true difference fits in WIDTH bits and the low bits are exact.
  always_comb begin
    partial_s = {rem_r, quo_r[WIDTH-1]};
    diff_s    = partial_s[WIDTH-1:0] - divisor_r;
    remNext_s = partial_s[WIDTH-1:0];
    quoNext_s = {quo_r[WIDTH-2:0], 1'b0};
    if (partial_s >= {1'b0, divisor_r}) begin
      remNext_s = diff_s;
      quoNext_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      remNext_s = partial_s[WIDTH-1:0];
      quoNext_s = {quo_r[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state logic; cancel forces IDLE from any state.
  always_comb begin
    nextState_s = state_r;
    if (divBus.cancel) begin
      nextState_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (divBus.div_startE) begin
            nextState_s = (divBus.srcbE == ZERO) ? DONE : BUSY;
          end else begin
            nextState_s = IDLE;
          end
        end
        BUSY: begin
          if (lastIter_s) begin
            nextState_s = DONE;
          end else begin
            nextState_s = BUSY;
          end
        end
        DONE: begin
          if (divBus.stall_ext) begin
            nextState_s = DONE;
          end else begin
            nextState_s = IDLE;
          end
        end
        default: nextState_s = IDLE;
      endcase
    end
  end

  // Stall request; never raised in DONE so the result leaves EX.
  always_comb begin
    stall_s = 1'b0;
    if (divBus.cancel) begin
      stall_s = 1'b0;
    end else begin
      stall_s = ((state_r == IDLE) & divBus.div_startE) | (state_r == BUSY);
    end
  end

  // State register and the DONE-decode valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      valid_r <= 1'b0;
    end else begin
      state_r <= nextState_s;
      valid_r <= (nextState_s == DONE);
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r     <= ZERO;
      quo_r     <= ZERO;
      divisor_r <= ZERO;
      hi_r      <= ZERO;
      lo_r      <= ZERO;
      negQ_r    <= 1'b0;
      negR_r    <= 1'b0;
      iterCnt_r <= CNT_ZERO;
    end else if (load_s) begin
      rem_r     <= ZERO;
      quo_r     <= absVal(divBus.srcaE, divBus.div_signedE);
      divisor_r <= absVal(divBus.srcbE, divBus.div_signedE);
      negQ_r    <= divBus.div_signedE & (divBus.srcaE[WIDTH-1] ^ divBus.srcbE[WIDTH-1]);
      negR_r    <= divBus.div_signedE & divBus.srcaE[WIDTH-1];
      iterCnt_r <= CNT_ZERO;
      // Divide by zero: raw dividend and all-ones quotient, no sign fix.
      if (divBus.srcbE == ZERO) begin
        hi_r <= divBus.srcaE;
        lo_r <= ONES;
      end
    end else if ((state_r == BUSY) && !divBus.cancel) begin
      rem_r     <= remNext_s;
      quo_r     <= quoNext_s;
      iterCnt_r <= iterCnt_r + CNT_ONE;
      // Result lands on the DONE entry edge and is held afterwards.
      if (lastIter_s) begin
        hi_r <= negIf(remNext_s, negR_r);
        lo_r <= negIf(quoNext_s, negQ_r);
      end
    end
  end

  assign divBus.div_stall = stall_s;
  assign divBus.div_valid = valid_r;
  assign divBus.hi_o      = hi_r;
  assign divBus.lo_o      = lo_r;

endmodule

// File: tb/tb_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_div_sequencer
// Directed self-checking bench for div_sequencer with hand-computed results.
// -----------------------------------------------------------------------------
module tb_div_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [31:0] prevLo;
  logic [31:0] prevHi;

  div_sequencer_if #(.WIDTH(32)) bus ();

  div_sequencer #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .divBus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
    end
  endtask

  // Runs one divide starting in the current cycle (state must be IDLE).
  // hold = number of cycles stall_ext is held high once DONE is reached.
  task automatic runDiv(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expLo,
                        input logic [31:0] expHi, input int expStall, input int hold);
    int cyc;
    int stallCnt;
    cyc      = 0;
    stallCnt = 0;
    bus.div_startE  = 1'b1;
    bus.div_signedE = sgn;
    bus.srcaE       = a;
    bus.srcbE       = b;
    #1;
    while (!bus.div_valid && cyc < 60) begin
      if (bus.div_stall) stallCnt++;
      @(negedge clk);
      #1;
      cyc++;
    end
    checkVal({tag, "_doneCycle"}, 32'(cyc), 32'(expStall));
    checkVal({tag, "_stallCnt"}, 32'(stallCnt), 32'(expStall));
    checkVal({tag, "_valid"}, {31'd0, bus.div_valid}, 32'd1);
    checkVal({tag, "_lo"}, bus.lo_o, expLo);
    checkVal({tag, "_hi"}, bus.hi_o, expHi);
    checkVal({tag, "_doneStall"}, {31'd0, bus.div_stall}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      bus.stall_ext = 1'b1;
      @(negedge clk);
      #1;
      checkVal({tag, "_holdValid"}, {31'd0, bus.div_valid}, 32'd1);
      checkVal({tag, "_holdLo"}, bus.lo_o, expLo);
      checkVal({tag, "_holdHi"}, bus.hi_o, expHi);
      checkVal({tag, "_holdStall"}, {31'd0, bus.div_stall}, 32'd0);
    end
    bus.stall_ext  = 1'b0;
    bus.div_startE = 1'b0;
    @(negedge clk);
    #1;
    checkVal({tag, "_idleValid"}, {31'd0, bus.div_valid}, 32'd0);
    checkVal({tag, "_idleStall"}, {31'd0, bus.div_stall}, 32'd0);
    checkVal({tag, "_idleLo"}, bus.lo_o, expLo);
    prevLo = expLo;
    prevHi = expHi;
  endtask

  initial begin
    logic sawValid;
    checks          = 0;
    failures        = 0;
    rst             = 1'b1;
    bus.div_startE  = 1'b0;
    bus.div_signedE = 1'b0;
    bus.srcaE       = 32'd0;
    bus.srcbE       = 32'd0;
    bus.cancel      = 1'b0;
    bus.stall_ext   = 1'b0;
    prevLo          = 32'd0;
    prevHi          = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkVal("rst_valid", {31'd0, bus.div_valid}, 32'd0);
    checkVal("rst_stall", {31'd0, bus.div_stall}, 32'd0);
    checkVal("rst_lo", bus.lo_o, 32'd0);
    checkVal("rst_hi", bus.hi_o, 32'd0);

    // Main function, signed/unsigned, edge operands
    runDiv("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 0);
    runDiv("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0);
    runDiv("div_7_m2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 33, 0);
    runDiv("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 33, 0);
    runDiv("divu_big", 1'b0, 32'h1234_5678, 32'h0000_1000, 32'h0001_2345, 32'h0000_0678, 33, 0);
    runDiv("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 33, 0);
    runDiv("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 0);
    runDiv("div_m7_0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1, 0);

    // stall_ext holds DONE for 3 cycles with start still high
    runDiv("stallExt", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 3);

    // Cancel in cycle 10, restart with divu 9/3 in cycle 11
    sawValid        = 1'b0;
    bus.div_startE  = 1'b1;
    bus.div_signedE = 1'b0;
    bus.srcaE       = 32'd1000;
    bus.srcbE       = 32'd10;
    #1;
    for (int i = 0; i < 10; i++) begin
      sawValid = sawValid | bus.div_valid;
      @(negedge clk);
      #1;
    end
    bus.cancel = 1'b1;
    #1;
    checkVal("cancel_stallDrop", {31'd0, bus.div_stall}, 32'd0);
    checkVal("cancel_noValidBefore", {31'd0, sawValid | bus.div_valid}, 32'd0);
    @(negedge clk);
    bus.cancel     = 1'b0;
    bus.div_startE = 1'b0;
    #1;
    checkVal("cancel_idleValid", {31'd0, bus.div_valid}, 32'd0);
    checkVal("cancel_loKept", bus.lo_o, prevLo);
    checkVal("cancel_hiKept", bus.hi_o, prevHi);
    runDiv("cancelRestart", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 0);

    // Reset in cycle 15 of a divide
    bus.div_startE  = 1'b1;
    bus.div_signedE = 1'b0;
    bus.srcaE       = 32'd77;
    bus.srcbE       = 32'd5;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst            = 1'b0;
    bus.div_startE = 1'b0;
    #1;
    checkVal("midRst_valid", {31'd0, bus.div_valid}, 32'd0);
    checkVal("midRst_stall", {31'd0, bus.div_stall}, 32'd0);
    checkVal("midRst_lo", bus.lo_o, 32'd0);
    checkVal("midRst_hi", bus.hi_o, 32'd0);

    // Still functional after the mid-divide reset
    runDiv("postRst", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 33, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
